// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: packs big-endian words and writes them at incrementing addresses.
// The optional inter-byte timeout is built only when LOADER_TIMEOUT_EN is defined.
module instr_mem_loader #(
  parameter int unsigned        NB_DATA      = 32,
  parameter int unsigned        NB_BYTE      = 8,
  parameter int unsigned        NB_ADDR_IMEM = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD    = '1
`ifdef LOADER_TIMEOUT_EN
  , parameter int unsigned      TIMEOUT_CYCLES = 1000
`endif
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [NB_BYTE-1:0]      i_rx_data,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic                    o_we_IF,
  output logic [NB_DATA-1:0]      o_instruction_data,
  output logic [NB_ADDR_IMEM-1:0] o_instr_addr,
  output logic                    o_halt,
  output logic                    o_done,
  output logic                    o_overflow,
  output logic [NB_ADDR_IMEM:0]   o_word_count,
  output logic                    o_timeout
);

  localparam int unsigned BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int unsigned NB_BCNT        = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int unsigned NB_WCNT        = NB_ADDR_IMEM + 1;
  localparam int unsigned NB_SHIFT       = NB_DATA - NB_BYTE;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(BYTES_PER_WORD - 1);
  localparam logic [NB_WCNT-1:0] LAST_WORD = {1'b0, {NB_ADDR_IMEM{1'b1}}};

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERROR} state_t;

  state_t               state;
  logic [NB_SHIFT-1:0]  shift_word;
  logic [NB_BCNT-1:0]   byte_cnt;
  logic [NB_DATA-1:0]   next_word;
  logic                 accept;
  logic                 restart;

  assign next_word = {shift_word, i_rx_data};
  assign accept    = i_rx_valid & o_rx_ready;
  // WRITE and DONE are not interruptible by a start request.
  assign restart   = i_start & ((state == IDLE) | (state == RECV) | (state == ERROR));

`ifdef LOADER_TIMEOUT_EN
  localparam int unsigned NB_TO = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NB_TO-1:0] TO_LAST = NB_TO'(TIMEOUT_CYCLES - 1);
  logic [NB_TO-1:0] idle_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= IDLE;
      shift_word         <= '0;
      byte_cnt           <= '0;
      o_rx_ready         <= 1'b0;
      o_we_IF            <= 1'b0;
      o_instruction_data <= '0;
      o_instr_addr       <= '0;
      o_halt             <= 1'b0;
      o_done             <= 1'b0;
      o_overflow         <= 1'b0;
      o_word_count       <= '0;
`ifdef LOADER_TIMEOUT_EN
      idle_cnt           <= '0;
      o_timeout          <= 1'b0;
`endif
    end else begin
      o_we_IF <= 1'b0;
      o_done  <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      o_timeout <= 1'b0;
`endif
      if (restart) begin
        state        <= RECV;
        byte_cnt     <= '0;
        o_instr_addr <= '0;
        o_word_count <= '0;
        o_overflow   <= 1'b0;
        o_halt       <= 1'b1;
        o_rx_ready   <= 1'b1;
`ifdef LOADER_TIMEOUT_EN
        idle_cnt     <= '0;
`endif
      end else begin
        case (state)
          RECV: begin
            if (accept) begin
              shift_word <= next_word[NB_SHIFT-1:0];
`ifdef LOADER_TIMEOUT_EN
              idle_cnt   <= '0;
`endif
              if (byte_cnt == LAST_BYTE) begin
                byte_cnt           <= '0;
                state              <= WRITE;
                o_rx_ready         <= 1'b0;
                o_we_IF            <= 1'b1;
                o_instruction_data <= next_word;
              end else begin
                byte_cnt <= byte_cnt + NB_BCNT'(1);
              end
            end
`ifdef LOADER_TIMEOUT_EN
            // A stalled partial word is dropped; address and count are untouched.
            else if (byte_cnt != '0) begin
              if (idle_cnt == TO_LAST) begin
                idle_cnt  <= '0;
                byte_cnt  <= '0;
                o_timeout <= 1'b1;
              end else begin
                idle_cnt <= idle_cnt + NB_TO'(1);
              end
            end
`endif
          end
          WRITE: begin
            o_instr_addr <= o_instr_addr + NB_ADDR_IMEM'(1);
            o_word_count <= o_word_count + NB_WCNT'(1);
            if (o_instruction_data == HALT_WORD) begin
              state  <= DONE;
              o_done <= 1'b1;
              o_halt <= 1'b0;
            end else if (o_word_count == LAST_WORD) begin
              state      <= ERROR;
              o_overflow <= 1'b1;
            end else begin
              state      <= RECV;
              o_rx_ready <= 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a cycle table for the basic load, then hand sequences for
// backpressure, overflow (second instance with a 4-word memory), restart, async reset and timeout.
module tb_instr_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;

  logic        a_ready, a_we, a_halt, a_done, a_overflow, a_timeout;
  logic [31:0] a_data;
  logic [7:0]  a_addr;
  logic [8:0]  a_wc;

  logic        b_ready, b_we, b_halt, b_done, b_overflow, b_timeout;
  logic [31:0] b_data;
  logic [1:0]  b_addr;
  logic [2:0]  b_wc;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        we;
    logic [31:0] wdata;
    logic [7:0]  addr;
    logic        halt;
    logic        done;
    logic [8:0]  wc;
  } vec_t;

  vec_t tbl[14];

  instr_mem_loader #(
    .NB_ADDR_IMEM(8)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut_a (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(a_ready), .o_we_IF(a_we), .o_instruction_data(a_data), .o_instr_addr(a_addr),
    .o_halt(a_halt), .o_done(a_done), .o_overflow(a_overflow), .o_word_count(a_wc),
    .o_timeout(a_timeout)
  );

  instr_mem_loader #(
    .NB_ADDR_IMEM(2)
`ifdef LOADER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut_b (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_rx_ready(b_ready), .o_we_IF(b_we), .o_instruction_data(b_data), .o_instr_addr(b_addr),
    .o_halt(b_halt), .o_done(b_done), .o_overflow(b_overflow), .o_word_count(b_wc),
    .o_timeout(b_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Record every write strobe; the loader must never offer ready during a write.
  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      qa.push_back({a_addr, a_data});
      chk("a_ready_during_write", 64'(a_ready), 64'd0);
    end
    if (b_we === 1'b1) qb.push_back({6'd0, b_addr, b_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (a_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    rx_valid = 1'b0;
    chk("byte_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic vec_t mk(input logic s, input logic v, input logic [7:0] d, input logic rdy,
                              input logic we, input logic [31:0] wd, input logic [7:0] ad,
                              input logic h, input logic dn, input logic [8:0] wc);
    vec_t r;
    r.start = s; r.valid = v; r.data = d; r.ready = rdy; r.we = we;
    r.wdata = wd; r.addr = ad; r.halt = h; r.done = dn; r.wc = wc;
    return r;
  endfunction

  initial begin
    logic [7:0]  bp_bytes[12];
    logic [31:0] bp_words[3];
    int          idx;
    logic        hs;
    int          pa, pb;

    // inputs applied in the cycle | outputs observed in that same cycle
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 32'h0,        8'd0, 0, 0, 9'd0);
    tbl[1]  = mk(0, 1, 8'h00, 1, 0, 32'h0,        8'd0, 1, 0, 9'd0);
    tbl[2]  = mk(0, 1, 8'h22, 1, 0, 32'h0,        8'd0, 1, 0, 9'd0);
    tbl[3]  = mk(0, 1, 8'h18, 1, 0, 32'h0,        8'd0, 1, 0, 9'd0);
    tbl[4]  = mk(0, 1, 8'h20, 1, 0, 32'h0,        8'd0, 1, 0, 9'd0);
    tbl[5]  = mk(1, 0, 8'h00, 0, 1, 32'h00221820, 8'd0, 1, 0, 9'd0);
    tbl[6]  = mk(0, 1, 8'hFF, 1, 0, 32'h0,        8'd1, 1, 0, 9'd1);
    tbl[7]  = mk(0, 1, 8'hFF, 1, 0, 32'h0,        8'd1, 1, 0, 9'd1);
    tbl[8]  = mk(0, 1, 8'hFF, 1, 0, 32'h0,        8'd1, 1, 0, 9'd1);
    tbl[9]  = mk(0, 1, 8'hFF, 1, 0, 32'h0,        8'd1, 1, 0, 9'd1);
    tbl[10] = mk(0, 0, 8'h00, 0, 1, 32'hFFFFFFFF, 8'd1, 1, 0, 9'd1);
    tbl[11] = mk(1, 0, 8'h00, 0, 0, 32'h0,        8'd2, 0, 1, 9'd2);
    tbl[12] = mk(0, 0, 8'h00, 0, 0, 32'h0,        8'd2, 0, 0, 9'd2);
    tbl[13] = mk(0, 0, 8'h00, 0, 0, 32'h0,        8'd2, 0, 0, 9'd2);

    for (int i = 0; i < 12; i++) bp_bytes[i] = 8'(i + 1);
    bp_words[0] = 32'h01020304;
    bp_words[1] = 32'h05060708;
    bp_words[2] = 32'h090A0B0C;

    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready",    64'(a_ready),    64'd0);
    chk("rst_we",       64'(a_we),       64'd0);
    chk("rst_data",     64'(a_data),     64'd0);
    chk("rst_addr",     64'(a_addr),     64'd0);
    chk("rst_halt",     64'(a_halt),     64'd0);
    chk("rst_done",     64'(a_done),     64'd0);
    chk("rst_overflow", 64'(a_overflow), 64'd0);
    chk("rst_wc",       64'(a_wc),       64'd0);
    chk("rst_timeout",  64'(a_timeout),  64'd0);
    rst_n = 1'b1;

    // Basic load of one instruction and the HALT word.
    for (int i = 0; i < 14; i++) begin
      start    = tbl[i].start;
      rx_valid = tbl[i].valid;
      rx_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("t%0d_ready", i), 64'(a_ready), 64'(tbl[i].ready));
      chk($sformatf("t%0d_we", i),    64'(a_we),    64'(tbl[i].we));
      chk($sformatf("t%0d_addr", i),  64'(a_addr),  64'(tbl[i].addr));
      chk($sformatf("t%0d_halt", i),  64'(a_halt),  64'(tbl[i].halt));
      chk($sformatf("t%0d_done", i),  64'(a_done),  64'(tbl[i].done));
      chk($sformatf("t%0d_wc", i),    64'(a_wc),    64'(tbl[i].wc));
      if (tbl[i].we) chk($sformatf("t%0d_wdata", i), 64'(a_data), 64'(tbl[i].wdata));
      @(posedge clk);
      #1;
    end
    start = 1'b0; rx_valid = 1'b0;

    // Backpressure: valid held high, byte advanced only on a handshake.
    qa.delete(); qb.delete();
    pulse_start();
    idx = 0;
    for (int k = 0; k < 100 && idx < 12; k++) begin
      rx_valid = 1'b1;
      rx_data  = bp_bytes[idx];
      @(negedge clk);
      hs = a_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
    end
    rx_valid = 1'b0;
    chk("bp_bytes_taken", 64'(idx), 64'd12);
    repeat (2) step();
    chk("bp_write_count", 64'(qa.size()), 64'd3);
    for (int j = 0; j < qa.size() && j < 3; j++) begin
      chk($sformatf("bp_addr%0d", j), 64'(qa[j].addr), 64'(j));
      chk($sformatf("bp_data%0d", j), 64'(qa[j].data), 64'(bp_words[j]));
    end
    chk("bp_wc", 64'(a_wc), 64'd3);

    // Overflow on the 4-word instance.
    qa.delete(); qb.delete();
    pulse_start();
    for (int w = 1; w <= 4; w++) send_word(32'h10000000 + 32'(w));
    step();
    chk("ovf_b_writes",   64'(qb.size()),  64'd4);
    for (int j = 0; j < qb.size() && j < 4; j++) begin
      chk($sformatf("ovf_b_addr%0d", j), 64'(qb[j].addr), 64'(j));
      chk($sformatf("ovf_b_data%0d", j), 64'(qb[j].data), 64'(32'h10000000 + 32'(j + 1)));
    end
    chk("ovf_b_flag",     64'(b_overflow), 64'd1);
    chk("ovf_b_halt",     64'(b_halt),     64'd1);
    chk("ovf_b_ready",    64'(b_ready),    64'd0);
    chk("ovf_b_done",     64'(b_done),     64'd0);
    chk("ovf_b_wc",       64'(b_wc),       64'd4);
    chk("ovf_a_flag",     64'(a_overflow), 64'd0);
    chk("ovf_a_ready",    64'(a_ready),    64'd1);
    send_word(32'h10000005);
    repeat (2) step();
    chk("ovf_b_no_5th",   64'(qb.size()),  64'd4);
    chk("ovf_a_5th",      64'(qa.size()),  64'd5);
    if (qa.size() == 5) chk("ovf_a_5th_wr", 64'(qa[4]), 64'({8'd4, 32'h10000005}));
    chk("ovf_b_sticky",   64'(b_overflow), 64'd1);
    pulse_start();
    chk("ovf_clr_flag",   64'(b_overflow), 64'd0);
    chk("ovf_clr_ready",  64'(b_ready),    64'd1);
    chk("ovf_clr_halt",   64'(b_halt),     64'd1);
    chk("ovf_clr_wc",     64'(b_wc),       64'd0);
    chk("ovf_clr_addr",   64'(b_addr),     64'd0);

    // Restart during a partial word; the byte presented with start is dropped.
    qa.delete(); qb.delete();
    send_byte(8'hAA);
    send_byte(8'hBB);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
    step();
    start = 1'b0; rx_valid = 1'b0;
    send_word(32'h8C220004);
    repeat (2) step();
    chk("rs_writes", 64'(qa.size()), 64'd1);
    if (qa.size() == 1) chk("rs_wr", 64'(qa[0]), 64'({8'd0, 32'h8C220004}));
    chk("rs_b_writes", 64'(qb.size()), 64'd1);

    // Asynchronous reset mid-word drops halt without a clock edge.
    send_byte(8'h55);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_halt",  64'(a_halt),  64'd0);
    chk("arst_ready", 64'(a_ready), 64'd0);
    chk("arst_wc",    64'(a_wc),    64'd0);
    step();
    rst_n = 1'b1;

    // Idle gap after one byte: timeout when built, otherwise the byte is kept.
    pulse_start();
    qa.delete(); qb.delete();
    send_byte(8'h11);
    pa = 0; pb = 0;
    repeat (20) begin
      @(negedge clk);
      if (a_timeout) pa++;
      if (b_timeout) pb++;
      @(posedge clk);
      #1;
    end
    send_word(32'hAABBCCDD);
    repeat (2) step();
    chk("to_writes", 64'(qa.size()), 64'd1);
`ifdef LOADER_TIMEOUT_EN
    chk("to_pulses_a", 64'(pa), 64'd1);
    chk("to_pulses_b", 64'(pb), 64'd1);
    if (qa.size() == 1) chk("to_wr", 64'(qa[0]), 64'({8'd0, 32'hAABBCCDD}));
`else
    chk("to_pulses_a", 64'(pa), 64'd0);
    chk("to_pulses_b", 64'(pb), 64'd0);
    if (qa.size() == 1) chk("to_wr", 64'(qa[0]), 64'({8'd0, 32'h11AABBCC}));
`endif
    chk("to_addr", 64'(a_addr), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
